muldiv_seq: RTL
===============

Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the unsigned-multiply (MULTU) resource and the HI/LO register pair in the pipelined MIPS core.
- Accepts a multiply from the EX stage using the ALU decoder's enable strobe.
- Runs a radix-2 shift-add multiply over WIDTH cycles, writes HI/LO, and serves MFHI/MFLO reads.
- Raises a stall to the hazard unit whenever a request collides with an in-flight multiply.

Parameters:
- WIDTH, 32, operand width and HI/LO register width.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
- clk  input  1  single core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mul_en  input  1  multiply request from EX (decoder enable strobe); level, held while stall=1.
- op_a  input  WIDTH  multiplicand (rs value).
- op_b  input  WIDTH  multiplier (rt value).
- mfhi_req  input  1  MFHI read request from EX.
- mflo_req  input  1  MFLO read request from EX.
- hilo_rd_data  output  WIDTH  HI, LO or 0 per the read request (combinational).
- busy  output  1  multiply in progress.
- done  output  1  one-cycle pulse after HI/LO are written.
- stall  output  1  freeze IF/ID/EX; combinational.
- hi  output  WIDTH  current HI register.
- lo  output  WIDTH  current LO register.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; HI, LO, accumulator, multiplier shadow and counter all cleared to 0.
  - busy=0, done=0, stall=0, hilo_rd_data=0.
  - Applies immediately, including mid-operation; the in-flight multiply is discarded and HI/LO are not written.
- States:
  - IDLE: idle.
  - RUN: iterating.
  - Transitions:
    - IDLE -> RUN on a rising edge with mul_en=1.
    - RUN -> IDLE on the edge where cnt==WIDTH-1.
    - No other transitions.
- Accept edge (IDLE, mul_en=1):
  - mcand<=op_a; mplier<=op_b; acc<=0; carry<=0; cnt<=0.
  - busy goes high from the next cycle.
- Each RUN edge:
  - sum[WIDTH:0] = acc + (mplier[0] ? mcand : 0).
  - {acc, mplier} <= {sum, mplier} >> 1, with sum[WIDTH] becoming acc MSB.
  - cnt<=cnt+1.
- Final RUN edge (cnt==WIDTH-1):
  - HI<=next acc; LO<=next mplier; state<=IDLE.
  - done=1 for exactly the following cycle.
- Latency:
  - Accept at edge E0; HI/LO updated at edge E0+WIDTH (E32 for default).
  - busy high for exactly WIDTH cycles.
  - Fixed latency; zero operands do not shortcut.
- stall = busy & (mul_en | mfhi_req | mflo_req).
  - Deasserts in the cycle after the final edge.
  - In that cycle reads see the new HI/LO and a held mul_en is accepted.
- hilo_rd_data:
  - mfhi_req ? HI : mflo_req ? LO : 0.
  - Both requests high is illegal; MFHI wins.
- Simultaneous mul_en and mfhi_req/mflo_req in IDLE:
  - Read returns the pre-multiply HI/LO (read-before-write); multiply is accepted the same edge.
- Back-to-back multiplies:
  - Second mul_en during RUN is stalled, then accepted in the done cycle.
  - No idle gap beyond that.
- mul_en=0 during RUN does not abort; there is no cancel input.
- Result is 2*WIDTH-bit unsigned; no overflow possible; carry captured via the WIDTH+1-bit sum.

Decomposition:
- Shared package mips_pkg:
  - typedef muldiv_state_t {IDLE, RUN}.
  - WIDTH default and CNT_W default.
  - Funct constants MULTU=6'b011001, MFHI=6'b010000, MFLO=6'b010010, shared with the decoder.
- One natural sub-module, hilo_regs:
  - HI/LO register pair with async active-low clear and write-enable.
  - Read mux for hilo_rd_data.
- Sequencer FSM and shift-add datapath stay in muldiv_seq.

Test Plan:
- Reset, then op_a=3, op_b=5, mul_en one cycle -> busy=1 for 32 cycles; done pulses once; HI=0x00000000, LO=0x0000000F.
- op_a=op_b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 32 cycles (exercises carry).
- Start 0x10000*0x10000, assert mfhi_req from cycle 2 -> stall=1 through cycle 32; stall=0 and hilo_rd_data=0x00000001 in the done cycle.
- HI/LO preloaded (7*9 → LO=63); in IDLE assert mflo_req and mul_en(2*2) together -> hilo_rd_data=63 that cycle, no stall; LO=4 after 32 cycles.
- Assert mul_en held for two ops (2*3 then 4*5) -> second accepted in done cycle; done pulses at +32 and +64; final LO=20.
- Start 0xFFFF*0xFFFF, drop rst_n at cycle 10 -> busy=0, stall=0, HI=LO=0 immediately; after release no done pulse and HI/LO stay 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: multiply/divide sequencer state type, default
// widths and the funct codes the ALU decoder uses for MULTU/MFHI/MFLO.
package mips_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 5;

  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_seq_if.sv
// EX-stage to multiply-sequencer bundle: request/operand signals from EX,
// HI/LO read data and hazard status back from the sequencer.
interface muldiv_seq_if
  import mips_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             mul_en;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             mfhi_req;
  logic             mflo_req;
  logic [WIDTH-1:0] hilo_rd_data;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output mul_en, op_a, op_b, mfhi_req, mflo_req,
    input  hilo_rd_data, busy, done, stall, hi, lo
  );

  modport slave (
    input  mul_en, op_a, op_b, mfhi_req, mflo_req,
    output hilo_rd_data, busy, done, stall, hi, lo
  );

endinterface

// File: rtl/muldiv_seq_hilo_regs.sv
// HI/LO architectural register pair with write enable and the MFHI/MFLO
// read mux; MFHI takes priority if both reads are requested.
module hilo_regs
  import mips_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [WIDTH-1:0] hi_wr_i,
  input  logic [WIDTH-1:0] lo_wr_i,
  input  logic             rd_hi_i,
  input  logic             rd_lo_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (we_i) begin
      hi_q <= hi_wr_i;
      lo_q <= lo_wr_i;
    end
  end

  // Reads see the registered value, so a same-cycle write is read-before-write.
  always_comb begin
    rd_data_o = '0;
    if (rd_hi_i)      rd_data_o = hi_q;
    else if (rd_lo_i) rd_data_o = lo_q;
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/muldiv_seq.sv
// MULTU sequencer: radix-2 shift-add unsigned multiply over WIDTH cycles,
// writes HI/LO on completion and stalls EX while a multiply is in flight.
module muldiv_seq
  import mips_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_seq_if.slave  bus
);

  muldiv_state_t    state_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] mplier_d;
  logic             lastIter;
  logic             hiloWe;

  // The WIDTH+1-bit sum keeps the carry, which shifts into the accumulator MSB.
  always_comb begin
    sum      = {1'b0, acc_q} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
    acc_d    = sum[WIDTH:1];
    mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
  end

  assign lastIter = (cnt_q == CNT_W'(WIDTH - 1));
  assign hiloWe   = (state_q == RUN) && lastIter;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.mul_en) begin
            mcand_q  <= bus.op_a;
            mplier_q <= bus.op_b;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (lastIter) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  hilo_regs #(
    .WIDTH(WIDTH)
  ) u_hilo (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (hiloWe),
    .hi_wr_i   (acc_d),
    .lo_wr_i   (mplier_d),
    .rd_hi_i   (bus.mfhi_req),
    .rd_lo_i   (bus.mflo_req),
    .hi_o      (bus.hi),
    .lo_o      (bus.lo),
    .rd_data_o (bus.hilo_rd_data)
  );

  assign bus.busy  = (state_q == RUN);
  assign bus.done  = done_q;
  assign bus.stall = bus.busy & (bus.mul_en | bus.mfhi_req | bus.mflo_req);

endmodule
